// File: rtl/input_vc_arbiter.sv
// Per-input-port VC arbiter: strict priority across classes, round-robin within a class,
// holds the chosen VC from grant to last beat. Optional REQ timeout: ARB_REQ_TIMEOUT_EN.
module input_vc_arbiter #(
  parameter  int VC_NUM     = 3,
  parameter  int PRIO_NUM   = 2,
  parameter  int OUTPUT_NUM = 8,
  parameter  int TIMEOUT    = 16,
  localparam int NV         = VC_NUM * PRIO_NUM,
  localparam int VW         = $clog2(NV),
  localparam int DW         = $clog2(OUTPUT_NUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [NV-1:0] has_packet,
  input  logic [DW-1:0] dest_i      [NV-1:0],
  input  logic [VW-1:0] output_vc_i [NV-1:0],
  input  logic          cts,
  input  logic          last,
  output logic          req,
  output logic [DW-1:0] req_dest,
  output logic [VW-1:0] req_out_vc,
  output logic [VW-1:0] selected_vc,
  output logic          busy
);

  localparam int LW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] sel_q, sel_d;
  logic [DW-1:0] dest_q, dest_d;
  logic [VW-1:0] ovc_q, ovc_d;
  logic          req_q, busy_q;
  logic [LW-1:0] rr_q [PRIO_NUM];
  logic [LW-1:0] rr_d [PRIO_NUM];
  logic [PRIO_NUM-1:0] cls_any;
  logic          pick_found;
  logic [VW-1:0] pick_vc;
  logic          adv;

  genvar gi;
  generate
    for (gi = 0; gi < PRIO_NUM; gi++) begin : g_cls
      assign cls_any[gi] = |has_packet[gi*VC_NUM +: VC_NUM];
    end
    // A non-positive limit would never let a timed-out request escape.
    if (TIMEOUT < 1) begin : g_timeout_range_err
    end
  endgenerate

  // Highest non-empty class wins; inside it, first requester at or after its pointer.
  always_comb begin : pick
    int l;
    pick_found = 1'b0;
    pick_vc    = '0;
    l          = 0;
    for (int p = PRIO_NUM - 1; p >= 0; p--) begin
      if (!pick_found && cls_any[p]) begin
        for (int i = 0; i < VC_NUM; i++) begin
          l = (int'(rr_q[p]) + i) % VC_NUM;
          if (!pick_found && has_packet[p*VC_NUM + l]) begin
            pick_found = 1'b1;
            pick_vc    = VW'(p*VC_NUM + l);
          end
        end
      end
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_hit;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign cnt_d       = (state_q == REQ && state_d == REQ) ? cnt_q + CW'(1) : '0;

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dest_d  = dest_q;
    ovc_d   = ovc_q;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_vc;
          dest_d  = dest_i[pick_vc];
          ovc_d   = output_vc_i[pick_vc];
          state_d = REQ;
        end
      end
      REQ: begin
        if (cts) begin
          if (last) begin
            state_d = IDLE;
            adv     = 1'b1;
          end else begin
            state_d = XFER;
          end
        end else if (!has_packet[sel_q]) begin
          state_d = IDLE;
`ifdef ARB_REQ_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d = IDLE;
          adv     = 1'b1;
`endif
        end
      end
      XFER: begin
        if (last) begin
          state_d = IDLE;
          adv     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : rr_next
    int cls;
    int loc;
    cls = int'(sel_q) / VC_NUM;
    loc = int'(sel_q) % VC_NUM;
    for (int p = 0; p < PRIO_NUM; p++) begin
      rr_d[p] = rr_q[p];
    end
    if (adv) rr_d[cls] = LW'((loc + 1) % VC_NUM);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      dest_q  <= '0;
      ovc_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int p = 0; p < PRIO_NUM; p++) rr_q[p] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dest_q  <= dest_d;
      ovc_q   <= ovc_d;
      req_q   <= (state_d == REQ);
      busy_q  <= (state_d != IDLE);
      for (int p = 0; p < PRIO_NUM; p++) rr_q[p] <= rr_d[p];
    end
  end

  assign req         = req_q;
  assign busy        = busy_q;
  assign selected_vc = sel_q;
  assign req_dest    = dest_q;
  assign req_out_vc  = ovc_q;

endmodule
